// File: rtl/uart_frame_codec_if.sv
// -----------------------------------------------------------------------------
// uart_frame_codec_if
// Signal bundle between the UART byte core / wide-word logic and the framing
// codec.
//   master : the codec side. It receives RX bytes, TX words and tx_ready, and
//            drives the assembled frame, its strobes and the TX byte stream.
//   slave  : the environment side, with every direction reversed.
// Signals:
//   rx_byte/rx_valid        byte strobe from the UART receiver
//   o_data/o_len            assembled frame and its byte count
//   o_valid/o_drop          frame-ready / partial-frame-dropped strobes
//   i_data/i_send           word to transmit and the transmit request
//   o_tx_busy/o_tx_done     TX occupancy and end-of-transfer strobe
//   tx_byte/tx_valid/tx_ready  byte handshake toward the UART transmitter
// -----------------------------------------------------------------------------
interface uart_frame_codec_if #(
  parameter int NBYTES = 10
);
  localparam int LW = $clog2(NBYTES + 1);

  logic [7:0]          rx_byte;
  logic                rx_valid;
  logic [8*NBYTES-1:0] o_data;
  logic [LW-1:0]       o_len;
  logic                o_valid;
  logic                o_drop;
  logic [8*NBYTES-1:0] i_data;
  logic                i_send;
  logic                o_tx_busy;
  logic                o_tx_done;
  logic [7:0]          tx_byte;
  logic                tx_valid;
  logic                tx_ready;

  modport master (
    input  rx_byte, rx_valid, i_data, i_send, tx_ready,
    output o_data, o_len, o_valid, o_drop, o_tx_busy, o_tx_done,
           tx_byte, tx_valid
  );

  modport slave (
    output rx_byte, rx_valid, i_data, i_send, tx_ready,
    input  o_data, o_len, o_valid, o_drop, o_tx_busy, o_tx_done,
           tx_byte, tx_valid
  );
endinterface

// File: rtl/uart_frame_codec.sv
// -----------------------------------------------------------------------------
// uart_frame_codec
// Byte <-> wide-word framing layer sitting between a UART byte core and the
// design's word-level logic.
//   RX : shifts incoming bytes into a NBYTES-wide word (first byte ends up in
//        the top byte of a full frame). A frame closes when NBYTES bytes have
//        arrived, or early on a terminator byte (TERM_EN). A partial frame
//        that sees no byte for GAP_CYC cycles is discarded (GAP_CYC=0: never).
//   TX : captures a word on i_send and streams it out MSB byte first over a
//        valid/ready handshake, then pulses o_tx_done for one cycle.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : uart_frame_codec_if.master, see the interface file
// The RX and TX paths share no state.
// -----------------------------------------------------------------------------
module uart_frame_codec #(
  parameter int         NBYTES    = 10,
  parameter bit         TERM_EN   = 1'b1,
  parameter logic [7:0] TERM_BYTE = 8'h0D,
  parameter int         GAP_CYC   = 0
) (
  input  logic                clk,
  input  logic                rst,
  uart_frame_codec_if.master  bus
);

  localparam int DW = 8 * NBYTES;
  localparam int LW = $clog2(NBYTES + 1);
  // Gap counter only needs to reach GAP_CYC-1.
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
  logic [LW-1:0] cnt_q,  cnt_d;
  logic [GW-1:0] gap_q,  gap_d;
  logic [DW-1:0] data_q, data_d;
  logic [LW-1:0] len_q,  len_d;
  logic          vld_q,  vld_d;
  logic          drop_q, drop_d;

  logic          expire;
  logic          is_term;
  logic [LW-1:0] base_cnt;

  always_comb begin
    expire = 1'b0;
    if (GAP_CYC != 0)
      expire = (cnt_q != '0) && (gap_q == GW'(GAP_CYC - 1));

    // A byte landing on the expiry cycle starts a fresh frame, so every
    // decision below works from the post-timeout count.
    base_cnt = expire ? '0 : cnt_q;
    is_term  = TERM_EN && (bus.rx_byte == TERM_BYTE);

    cnt_d  = base_cnt;
    data_d = data_q;
    len_d  = len_q;
    vld_d  = 1'b0;
    drop_d = expire;

    // Gap counter runs only while a partial frame is held.
    gap_d = gap_q + GW'(1);
    if (bus.rx_valid || expire || (cnt_q == '0))
      gap_d = '0;

    if (bus.rx_valid) begin
      if (is_term) begin
        // Terminator is never stored; with nothing buffered it is ignored.
        if (base_cnt != '0) begin
          vld_d = 1'b1;
          len_d = base_cnt;
          cnt_d = '0;
        end
      end else begin
        data_d = {data_q[DW-9:0], bus.rx_byte};
        if (base_cnt == LW'(NBYTES - 1)) begin
          vld_d = 1'b1;
          len_d = LW'(NBYTES);
          cnt_d = '0;
        end else begin
          cnt_d = base_cnt + LW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      gap_q  <= '0;
      data_q <= '0;
      len_q  <= '0;
      vld_q  <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      gap_q  <= gap_d;
      data_q <= data_d;
      len_q  <= len_d;
      vld_q  <= vld_d;
      drop_q <= drop_d;
    end
  end

  assign bus.o_data  = data_q;
  assign bus.o_len   = len_q;
  assign bus.o_valid = vld_q;
  assign bus.o_drop  = drop_q;

  // ---------------------------------------------------------------------------
  // TX path
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_DONE
  } tx_state_e;

  tx_state_e     state_q, state_d;
  logic [DW-1:0] sh_q,    sh_d;
  logic [LW-1:0] rem_q,   rem_d;
  logic          tx_valid_c;
  logic          busy_c;
  logic          done_c;

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    rem_d      = rem_q;
    tx_valid_c = 1'b0;
    busy_c     = 1'b1;
    done_c     = 1'b0;

    unique case (state_q)
      TX_IDLE: begin
        busy_c = 1'b0;
        if (bus.i_send) begin
          sh_d    = bus.i_data;
          rem_d   = LW'(NBYTES);
          state_d = TX_SEND;
        end
      end
      TX_SEND: begin
        tx_valid_c = 1'b1;
        // Shift only on acceptance so tx_byte stays put under backpressure.
        if (bus.tx_ready) begin
          sh_d  = {sh_q[DW-9:0], 8'h00};
          rem_d = rem_q - LW'(1);
          if (rem_q == LW'(1))
            state_d = TX_DONE;
        end
      end
      TX_DONE: begin
        done_c  = 1'b1;
        state_d = TX_IDLE;
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      sh_q    <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      rem_q   <= rem_d;
    end
  end

  // A completed transfer leaves the shift register empty, so tx_byte reads
  // zero whenever the path is idle.
  assign bus.tx_byte   = sh_q[DW-1 -: 8];
  assign bus.tx_valid  = tx_valid_c;
  assign bus.o_tx_busy = busy_c;
  assign bus.o_tx_done = done_c;

endmodule

// File: tb/tb_uart_frame_codec.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_codec
// Directed bench for uart_frame_codec with NBYTES=10, TERM_EN=1,
// TERM_BYTE=8'h0D, GAP_CYC=100. Inputs change 1 time unit after a rising
// edge; outputs are sampled at the same point, after the registers update.
// -----------------------------------------------------------------------------
module tb_uart_frame_codec;

  localparam int NB = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_frame_codec_if #(.NBYTES(NB)) bus ();

  uart_frame_codec #(
    .NBYTES    (NB),
    .TERM_EN   (1'b1),
    .TERM_BYTE (8'h0D),
    .GAP_CYC   (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // Strobe monitors
  int vcnt = 0;
  int dcnt = 0;
  int both = 0;
  always @(negedge clk) begin
    if (bus.o_valid) vcnt <= vcnt + 1;
    if (bus.o_drop)  dcnt <= dcnt + 1;
    if (bus.o_valid && bus.o_drop) both <= both + 1;
  end

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rx(input logic [7:0] b);
    bus.rx_byte  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_o_valid"},  bus.o_valid,   0);
    chk({tag, "_o_drop"},   bus.o_drop,    0);
    chk({tag, "_o_data"},   bus.o_data,    0);
    chk({tag, "_o_len"},    bus.o_len,     0);
    chk({tag, "_tx_valid"}, bus.tx_valid,  0);
    chk({tag, "_tx_byte"},  bus.tx_byte,   0);
    chk({tag, "_busy"},     bus.o_tx_busy, 0);
    chk({tag, "_done"},     bus.o_tx_done, 0);
  endtask

  // Watchdog: the directed sequence is well under 2000 cycles.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [79:0] w;
    logic [79:0] w2;
    int v0, d0;

    bus.rx_byte  = 8'h00;
    bus.rx_valid = 1'b0;
    bus.i_data   = '0;
    bus.i_send   = 1'b0;
    bus.tx_ready = 1'b0;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // ---------------- full RX frame, 3 idle cycles between bytes ----------
    v0 = vcnt; d0 = dcnt;
    for (int i = 1; i <= 10; i++) begin
      rx(8'(i));
      if (i == 9) chk("full_no_early_valid", bus.o_valid, 0);
      if (i < 10) repeat (3) tick();
    end
    chk("full_valid", bus.o_valid, 1);
    chk("full_len",   bus.o_len,   10);
    chk("full_data",  bus.o_data,  80'h0102030405060708090A);
    tick();
    chk("full_valid_1cyc", bus.o_valid, 0);
    chk("full_data_held",  bus.o_data,  80'h0102030405060708090A);
    tick();
    chk("full_vcount", 32'(vcnt - v0), 1);
    chk("full_dcount", 32'(dcnt - d0), 0);

    // ---------------- terminator ----------------
    rx(8'h41); rx(8'h42); rx(8'h43);
    chk("term_not_yet", bus.o_valid, 0);
    rx(8'h0D);
    chk("term_valid", bus.o_valid, 1);
    chk("term_len",   bus.o_len,   3);
    chk("term_data",  bus.o_data[23:0], 24'h414243);
    chk("term_stale", bus.o_data,  80'h0405060708090A414243);
    tick();
    v0 = vcnt;
    rx(8'h0D);
    chk("lone_term_valid", bus.o_valid, 0);
    repeat (2) tick();
    chk("lone_term_vcount", 32'(vcnt - v0), 0);

    // ---------------- gap timeout ----------------
    v0 = vcnt; d0 = dcnt;
    rx(8'h11); rx(8'h22);
    repeat (99) tick();
    chk("gap_before", bus.o_drop, 0);
    tick();
    chk("gap_drop",       bus.o_drop,  1);
    chk("gap_drop_novld", bus.o_valid, 0);
    tick();
    chk("gap_drop_1cyc", bus.o_drop, 0);
    tick();
    chk("gap_dcount", 32'(dcnt - d0), 1);
    chk("gap_vcount", 32'(vcnt - v0), 0);
    for (int i = 0; i < 10; i++) rx(8'hA0 + 8'(i));
    chk("gap_next_valid", bus.o_valid, 1);
    chk("gap_next_len",   bus.o_len,   10);
    chk("gap_next_data",  bus.o_data,  80'hA0A1A2A3A4A5A6A7A8A9);
    tick();

    // ---------------- byte on the expiry cycle ----------------
    rx(8'h55);
    repeat (99) tick();
    rx(8'h66);
    chk("same_cyc_drop",  bus.o_drop,  1);
    chk("same_cyc_novld", bus.o_valid, 0);
    for (int i = 1; i < 10; i++) rx(8'h66 + 8'(i));
    chk("same_cyc_valid", bus.o_valid, 1);
    chk("same_cyc_data",  bus.o_data,  80'h666768696A6B6C6D6E6F);
    tick();

    // ---------------- TX with backpressure ----------------
    w = 80'hDEADBEEF00112233CAFE;
    chk("tx_idle_busy", bus.o_tx_busy, 0);
    bus.i_data = w;
    bus.i_send = 1'b1;
    tick();
    bus.i_send = 1'b0;
    bus.i_data = 80'h5555_5555_5555_5555_5555;
    chk("tx_first_valid", bus.tx_valid,  1);
    chk("tx_busy",        bus.o_tx_busy, 1);
    for (int i = 0; i < 10; i++) begin
      bus.tx_ready = 1'b0;
      if (i == 4) bus.i_send = 1'b1;
      chk("tx_byte_wait", bus.tx_byte, w[79 - 8*i -: 8]);
      tick();
      bus.i_send = 1'b0;
      chk("tx_byte_held", bus.tx_byte, w[79 - 8*i -: 8]);
      chk("tx_valid_held", bus.tx_valid, 1);
      bus.tx_ready = 1'b1;
      tick();
    end
    bus.tx_ready = 1'b0;
    chk("tx_done",        bus.o_tx_done, 1);
    chk("tx_done_busy",   bus.o_tx_busy, 1);
    chk("tx_done_novld",  bus.tx_valid,  0);
    tick();
    chk("tx_done_1cyc",   bus.o_tx_done, 0);
    chk("tx_idle_again",  bus.o_tx_busy, 0);
    tick();
    chk("tx_no_requeue",  bus.tx_valid,  0);

    // ---------------- reset mid-operation ----------------
    rx(8'hB1); rx(8'hB2); rx(8'hB3); rx(8'hB4);
    bus.i_data   = w;
    bus.tx_ready = 1'b1;
    bus.i_send   = 1'b1;
    tick();
    bus.i_send = 1'b0;
    repeat (3) tick();
    chk("mid_tx_byte4", bus.tx_byte, 8'hEF);
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    bus.tx_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      rx(8'hC0 + 8'(i));
      if (i == 5) chk("post_rst_no_early", bus.o_valid, 0);
    end
    chk("post_rst_valid", bus.o_valid, 1);
    chk("post_rst_len",   bus.o_len,   10);
    chk("post_rst_data",  bus.o_data,  80'hC0C1C2C3C4C5C6C7C8C9);
    bus.i_data = w;
    bus.i_send = 1'b1;
    tick();
    bus.i_send = 1'b0;
    chk("post_rst_tx_first", bus.tx_byte, 8'hDE);
    bus.tx_ready = 1'b1;
    repeat (10) tick();
    chk("post_rst_tx_done", bus.o_tx_done, 1);
    bus.tx_ready = 1'b0;
    tick();

    // ---------------- concurrent RX and TX ----------------
    w2 = 80'h0F1E2D3C4B5A69788796;
    v0 = vcnt;
    bus.tx_ready = 1'b1;
    bus.i_data   = w2;
    bus.i_send   = 1'b1;
    bus.rx_byte  = 8'h30;
    bus.rx_valid = 1'b1;
    tick();
    bus.i_send = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("conc_tx_valid", bus.tx_valid, 1);
      chk("conc_tx_byte",  bus.tx_byte,  w2[79 - 8*i -: 8]);
      if (i == 9) begin
        chk("conc_rx_valid", bus.o_valid, 1);
        chk("conc_rx_len",   bus.o_len,   10);
        chk("conc_rx_data",  bus.o_data,  80'h30313233343536373839);
      end
      bus.rx_byte  = 8'h31 + 8'(i);
      bus.rx_valid = (i < 9);
      tick();
    end
    bus.rx_valid = 1'b0;
    chk("conc_tx_done", bus.o_tx_done, 1);
    bus.tx_ready = 1'b0;
    repeat (2) tick();
    chk("conc_vcount", 32'(vcnt - v0), 1);
    chk("never_both",  32'(both), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_frame_codec.md
Name: uart_frame_codec

Overview:
- Parametrised byte-to-word framing layer between a UART byte core and the design's wide-word logic.
- RX path assembles NBYTES received bytes into one word. Frames can close early on a terminator byte, and stale partial frames are dropped after an inter-byte gap timeout.
- TX path serialises a wide word into bytes, MSB byte first, using a valid/ready byte handshake toward the UART transmitter.

Parameters:
- NBYTES, 10, bytes per full frame (≥2).
- TERM_EN, 1, enable early frame close on terminator byte.
- TERM_BYTE, 8'h0D, terminator value.
- GAP_CYC, 0, inter-byte timeout in clk cycles; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_byte  in  8  byte from UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_byte is valid.
- o_data  out  8*NBYTES  assembled frame.
- o_len  out  $clog2(NBYTES+1)  number of bytes in the frame.
- o_valid  out  1  one-cycle strobe; o_data and o_len are valid.
- o_drop  out  1  one-cycle strobe; partial frame discarded by timeout.
- i_data  in  8*NBYTES  word to transmit.
- i_send  in  1  transmit request.
- o_tx_busy  out  1  TX path occupied.
- o_tx_done  out  1  one-cycle strobe after the last byte is accepted.
- tx_byte  out  8  byte to UART transmitter.
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  UART transmitter accepts a byte.

Behaviour:
- Reset (asynchronous, any state):
  - All outputs go to 0.
  - RX count, gap counter and shift register are cleared.
  - TX FSM returns to IDLE.
  - Any partial frame or transfer in progress is abandoned with no strobe.
- RX shift:
  - On rx_valid with a non-terminator byte: o_data ← {o_data[8*NBYTES-9:0], rx_byte}; count increments.
  - The first byte received ends up in the top byte of a full frame.
- RX full frame:
  - When count reaches NBYTES, o_valid=1 on the following cycle with o_len=NBYTES.
  - count returns to 0 in the same cycle.
  - o_data holds its value until the next accepted byte.
- RX terminator (TERM_EN=1, rx_byte==TERM_BYTE):
  - count>0: the terminator is not stored; o_valid pulses next cycle with o_len=count, data right-aligned (upper bytes hold stale contents); count ← 0.
  - count==0: byte is ignored, no strobe.
  - TERM_EN=0: TERM_BYTE is treated as ordinary data.
- Gap timeout (GAP_CYC>0):
  - Gap counter resets on every rx_valid and runs only while count>0.
  - Reaching GAP_CYC: count ← 0 and o_drop pulses once; o_valid stays low.
- Strobe timing: o_valid and o_drop are registered, exactly one cycle wide, and never high together.
- Same-cycle events: rx_valid arriving on the cycle the timeout expires is counted as the first byte of a new frame; the old partial frame is still dropped and o_drop pulses.
- TX FSM states: IDLE, SEND, DONE.
  - IDLE: o_tx_busy=0. On i_send, capture i_data into the TX shift register, set remaining=NBYTES, go to SEND.
  - SEND: tx_valid=1, tx_byte=top byte of the shift register.
    - On tx_valid&&tx_ready: shift left by 8 and decrement remaining.
    - When the last byte is accepted, go to DONE.
    - tx_byte is held stable while tx_ready is low.
  - DONE: o_tx_done=1 for one cycle, then IDLE.
  - o_tx_busy=1 in SEND and DONE.
  - i_send outside IDLE is ignored; it is not queued.
- Independence: RX and TX paths share no state and operate concurrently.
- Latency:
  - RX: last byte strobe to o_valid is 1 cycle.
  - TX: i_send to first tx_valid is 1 cycle.
  - With tx_ready held high, the full transfer takes NBYTES cycles plus 1 DONE cycle.

Test Plan:
- Full RX frame: NBYTES=10, send bytes 0x01..0x0A with 3 idle cycles between each → single o_valid, o_data=80'h0102030405060708090A, o_len=10; o_drop never asserts.
- Terminator: send 0x41,0x42,0x43,0x0D → o_valid one cycle after 0x0D, o_len=3, o_data[23:0]=24'h414243. A lone 0x0D with count==0 → no strobe.
- Gap timeout: GAP_CYC=100; send 0x11,0x22, then idle 100 cycles → o_drop pulse, no o_valid. Next 10 bytes 0xA0..0xA9 → o_valid with o_data=80'hA0A1A2A3A4A5A6A7A8A9.
- TX with backpressure: i_data=80'hDEADBEEF00112233CAFE, i_send pulse, tx_ready toggling 1-0-1-0 → tx_byte sequence DE,AD,BE,EF,00,11,22,33,CA,FE, each held stable while tx_ready=0. o_tx_done pulses once; a second i_send mid-transfer is ignored.
- Reset mid-operation: assert rst after 4 RX bytes and 3 TX bytes → all outputs 0 immediately. After release, a clean 10-byte frame yields o_len=10 and correct data; i_send restarts from byte 0.
- Concurrency: a full RX frame and a full TX transfer running simultaneously → both complete correctly with no interaction.
